// File: rtl/rx_sipo_sampler.sv
// ============================================================================
//  Module      : rx_sipo_sampler
//  Description : UART receive front end. Synchronises the raw serial line,
//                detects the start bit, samples every bit at mid-period using
//                an oversampling baud tick, shifts the frame LSB-first into a
//                parallel register and pulses frame_ready once per frame.
//                Stop and parity bits are delivered unchecked.
//
//  Optional    : RX_MAJORITY_VOTE_EN
//                  defined   - each bit is the majority of three samples
//                              around the nominal sample point
//                  undefined - single sample at the nominal sample point
//
//  Parameters  : OVERSAMPLE  baud_tick pulses per bit (even, >= 4)
//                FRAME_BITS  bits per frame including start and stop
//
//  Ports       : clk             system clock
//                rst_n           asynchronous active-low reset
//                rx_serial       raw serial line, idle high
//                baud_tick       one-clk pulse at OVERSAMPLE x baud rate
//                rx_enable       receiver enable, low forces IDLE
//                frame_parallel  assembled frame, bit0 = start
//                frame_ready     one-clk pulse, frame_parallel valid
//                rx_busy         high whenever the receiver is not IDLE
//                start_glitch    one-clk pulse on a rejected false start
//
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rx_sipo_sampler #(
    parameter int OVERSAMPLE = 16,
    parameter int FRAME_BITS = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_serial,
    input  logic                  baud_tick,
    input  logic                  rx_enable,
    output logic [FRAME_BITS-1:0] frame_parallel,
    output logic                  frame_ready,
    output logic                  rx_busy,
    output logic                  start_glitch
);

    localparam int CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (FRAME_BITS > 2) ? $clog2(FRAME_BITS) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // Counter values at which a bit decision is taken. With voting the
    // decision is one tick after the nominal centre, because the third vote
    // sample lands there. The following bit period is still OVERSAMPLE
    // ticks, so the vote windows stay centred on every later bit.
`ifdef RX_MAJORITY_VOTE_EN
    localparam logic [CW-1:0] c_start_v0  = CW'(OVERSAMPLE/2 - 2);
    localparam logic [CW-1:0] c_start_v1  = CW'(OVERSAMPLE/2 - 1);
    localparam logic [CW-1:0] c_start_dec = CW'(OVERSAMPLE/2);
    localparam logic [CW-1:0] c_bit_v0    = CW'(OVERSAMPLE - 3);
    localparam logic [CW-1:0] c_bit_v1    = CW'(OVERSAMPLE - 2);
`else
    localparam logic [CW-1:0] c_start_dec = CW'(OVERSAMPLE/2 - 1);
`endif
    localparam logic [CW-1:0] c_bit_dec   = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] c_last_data = BW'(FRAME_BITS - 2);

    // ------------------------------------------------------------------
    // Input synchroniser (idle-high reset so no false start after reset)
    // ------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;
    logic w_rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_serial;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [CW-1:0]         r_cnt;
    logic [BW-1:0]         r_bit_idx;
    // Upper FRAME_BITS-1 bits of the conceptual shift register. The lowest
    // conceptual bit is always shifted out before anyone reads it, so it is
    // not stored; the complete frame is formed on the final shift.
    logic [FRAME_BITS-2:0] r_shreg;
    logic [FRAME_BITS-1:0] w_frame_next;

    logic                  w_bit_value;
    logic                  w_start_dec;
    logic                  w_bit_dec;
    logic                  w_shift_en;
    logic                  w_frame_done;
    logic                  w_glitch;
    logic                  w_busy_next;

    assign w_start_dec = baud_tick && (r_state == S_START) && (r_cnt == c_start_dec);
    assign w_bit_dec   = baud_tick && ((r_state == S_SHIFT) || (r_state == S_STOP))
                         && (r_cnt == c_bit_dec);

    // ------------------------------------------------------------------
    // Bit value: single sample or three-sample majority
    // ------------------------------------------------------------------
`ifdef RX_MAJORITY_VOTE_EN
    logic r_vote0;
    logic r_vote1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vote0 <= 1'b1;
            r_vote1 <= 1'b1;
        end else if (baud_tick) begin
            if (((r_state == S_START) && (r_cnt == c_start_v0)) ||
                (((r_state == S_SHIFT) || (r_state == S_STOP)) && (r_cnt == c_bit_v0))) begin
                r_vote0 <= w_rx_s;
            end
            if (((r_state == S_START) && (r_cnt == c_start_v1)) ||
                (((r_state == S_SHIFT) || (r_state == S_STOP)) && (r_cnt == c_bit_v1))) begin
                r_vote1 <= w_rx_s;
            end
        end
    end

    assign w_bit_value = (r_vote0 & r_vote1) | (r_vote0 & w_rx_s) | (r_vote1 & w_rx_s);
`else
    assign w_bit_value = w_rx_s;
`endif

    assign w_frame_next = {w_bit_value, r_shreg};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic (disable overrides any coincident tick)
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (!rx_enable) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (baud_tick && !w_rx_s) begin
                        w_state_next = S_START;
                    end
                end
                S_START: begin
                    if (w_start_dec) begin
                        w_state_next = w_bit_value ? S_IDLE : S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_bit_dec && (r_bit_idx == c_last_data)) begin
                        w_state_next = S_STOP;
                    end
                end
                S_STOP: begin
                    // Leave at mid-stop-bit so a back-to-back start is seen.
                    if (w_bit_dec) begin
                        w_state_next = S_IDLE;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_frame_done = 1'b0;
        w_glitch     = 1'b0;
        w_shift_en   = 1'b0;
        w_busy_next  = (w_state_next != S_IDLE);
        if (rx_enable) begin
            w_frame_done = (r_state == S_STOP) && w_bit_dec;
            w_glitch     = w_start_dec && w_bit_value;
            w_shift_en   = (w_start_dec && !w_bit_value) || w_bit_dec;
        end
    end

    // ------------------------------------------------------------------
    // Tick counter, bit counter and shift register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
        end else if (!rx_enable) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
        end else if (baud_tick) begin
            case (r_state)
                S_IDLE: begin
                    r_cnt     <= '0;
                    r_bit_idx <= '0;
                end
                S_START: begin
                    if (w_start_dec) begin
                        r_cnt     <= '0;
                        r_bit_idx <= w_bit_value ? '0 : BW'(1);
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_SHIFT: begin
                    if (w_bit_dec) begin
                        r_cnt     <= '0;
                        r_bit_idx <= r_bit_idx + BW'(1);
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (w_bit_dec) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_cnt     <= '0;
                    r_bit_idx <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg <= '0;
        end else if (w_shift_en) begin
            r_shreg <= w_frame_next[FRAME_BITS-1:1];
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    logic [FRAME_BITS-1:0] r_frame_parallel;
    logic                  r_frame_ready;
    logic                  r_busy;
    logic                  r_start_glitch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_parallel <= '0;
            r_frame_ready    <= 1'b0;
            r_busy           <= 1'b0;
            r_start_glitch   <= 1'b0;
        end else begin
            r_frame_ready  <= w_frame_done;
            r_start_glitch <= w_glitch;
            r_busy         <= w_busy_next;
            if (w_frame_done) begin
                r_frame_parallel <= w_frame_next;
            end
        end
    end

    assign frame_parallel = r_frame_parallel;
    assign frame_ready    = r_frame_ready;
    assign rx_busy        = r_busy;
    assign start_glitch   = r_start_glitch;

endmodule

`default_nettype wire

// File: tb/tb_rx_sipo_sampler.sv
// ============================================================================
//  Module      : tb_rx_sipo_sampler
//  Description : Self-checking bench for rx_sipo_sampler. Frames are built
//                from {stop, parity, data, start} and driven on the serial
//                line in units of baud ticks; received frames are compared
//                against the expected frames and a latency window.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rx_sipo_sampler;

    localparam int OS = 16;
    localparam int FB = 11;
    // Ticks from the tick preceding the start edge to the frame_ready cycle:
    // 10.5 bit periods plus synchroniser / tick-alignment slack.
    localparam int LAT_MIN = 169;
    localparam int LAT_MAX = 172;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx_serial;
    logic          baud_tick;
    logic          rx_enable;
    logic [FB-1:0] frame_parallel;
    logic          frame_ready;
    logic          rx_busy;
    logic          start_glitch;

    rx_sipo_sampler #(
        .OVERSAMPLE (OS),
        .FRAME_BITS (FB)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_serial      (rx_serial),
        .baud_tick      (baud_tick),
        .rx_enable      (rx_enable),
        .frame_parallel (frame_parallel),
        .frame_ready    (frame_ready),
        .rx_busy        (rx_busy),
        .start_glitch   (start_glitch)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ------------------------------------------------------------------
    // Baud tick generator: random spacing, or a fixed period of 2 clk
    // ------------------------------------------------------------------
    bit fixed_ticks = 1'b0;
    int tick_cnt    = 0;

    initial begin
        int gap;
        gap       = 0;
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (gap == 0) begin
                baud_tick = 1'b1;
                gap = fixed_ticks ? 1 : int'($urandom_range(0, 2));
            end else begin
                baud_tick = 1'b0;
                gap--;
            end
        end
    end

    always @(posedge clk) begin
        if (baud_tick) tick_cnt <= tick_cnt + 1;
    end

    // ------------------------------------------------------------------
    // Output monitor
    // ------------------------------------------------------------------
    logic [FB-1:0] got_q[$];
    int            got_tick_q[$];
    int            glitch_cnt = 0;
    int            both_cnt   = 0;
    bit            busy_seen  = 1'b0;

    always @(negedge clk) begin
        if (frame_ready) begin
            got_q.push_back(frame_parallel);
            got_tick_q.push_back(tick_cnt);
        end
        if (start_glitch) glitch_cnt++;
        if (frame_ready && start_glitch) both_cnt++;
        if (rx_busy) busy_seen = 1'b1;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic wait_tick();
        do @(posedge clk); while (baud_tick !== 1'b1);
        #1;
    endtask

    task automatic idle_ticks(input int n);
        rx_serial = 1'b1;
        repeat (n) wait_tick();
    endtask

    function automatic logic [FB-1:0] make_frame(input logic [7:0] d, input logic p,
                                                 input logic s);
        return {s, p, d, 1'b0};
    endfunction

    // Drives one frame, OS ticks per bit. spike inverts the line for the
    // single tick that lands on the centre of each data bit. abort_bit >= 0
    // drops rx_enable four ticks into that bit and ends the frame there.
    task automatic send_frame(input logic [FB-1:0] f, input bit spike,
                              input int abort_bit, output int t0);
        t0 = tick_cnt;
        for (int k = 0; k < FB; k++) begin
            for (int j = 0; j < OS; j++) begin
                if (k == abort_bit && j == 4) begin
                    rx_enable = 1'b0;
                    rx_serial = 1'b1;
                    return;
                end
                rx_serial = (spike && k >= 1 && k <= 8 && j == 8) ? ~f[k] : f[k];
                wait_tick();
            end
        end
    endtask

    task automatic wait_frames(input int n);
        int c;
        c = 0;
        while (got_q.size() < n && c < 4000) begin
            @(posedge clk);
            c++;
        end
        #1;
    endtask

    task automatic clear_obs();
        got_q.delete();
        got_tick_q.delete();
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n     = 1'b0;
        rx_enable = 1'b0;
        rx_serial = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({frame_parallel, frame_ready, rx_busy, start_glitch} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got fp=%h fr=%b busy=%b sg=%b, want all 0",
                     frame_parallel, frame_ready, rx_busy, start_glitch);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        rx_enable = 1'b1;
        clear_obs();
        glitch_cnt = 0;
        idle_ticks(100);
        checks++;
        if (got_q.size() != 0) begin
            errors++;
            $display("FAIL idle_no_frame: got %0d frames, want 0", got_q.size());
        end
        checks++;
        if (rx_busy !== 1'b0 || frame_parallel !== '0 || glitch_cnt != 0) begin
            errors++;
            $display("FAIL idle_state: got busy=%b fp=%h glitches=%0d, want 0/000/0",
                     rx_busy, frame_parallel, glitch_cnt);
        end
    endtask

    task automatic test_single_frame();
        int t0;
        clear_obs();
        busy_seen = 1'b0;
        send_frame(make_frame(8'hA5, 1'b0, 1'b1), 1'b0, -1, t0);
        idle_ticks(8);
        wait_frames(1);
        checks++;
        if (got_q.size() != 1) begin
            errors++;
            $display("FAIL a5_count: got %0d frames, want 1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== 11'h54A) begin
                errors++;
                $display("FAIL a5_value: got %h, want 54a", got_q[0]);
            end
            checks++;
            if (got_tick_q[0] - t0 < LAT_MIN || got_tick_q[0] - t0 > LAT_MAX) begin
                errors++;
                $display("FAIL a5_latency: got %0d ticks, want %0d..%0d",
                         got_tick_q[0] - t0, LAT_MIN, LAT_MAX);
            end
        end
        checks++;
        if (busy_seen !== 1'b1 || rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL a5_busy: got seen=%b now=%b, want 1/0", busy_seen, rx_busy);
        end
    endtask

    task automatic test_glitch();
        int g0;
        clear_obs();
        g0 = glitch_cnt;
        rx_serial = 1'b0;
        repeat (4) wait_tick();
        idle_ticks(30);
        checks++;
        if (glitch_cnt != g0 + 1) begin
            errors++;
            $display("FAIL glitch_pulse: got %0d pulses, want 1", glitch_cnt - g0);
        end
        checks++;
        if (got_q.size() != 0 || rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_idle: got frames=%0d busy=%b, want 0/0",
                     got_q.size(), rx_busy);
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        int t1;
        clear_obs();
        send_frame(make_frame(8'h00, 1'b0, 1'b1), 1'b0, -1, t0);
        send_frame(make_frame(8'hFF, 1'b0, 1'b1), 1'b0, -1, t1);
        idle_ticks(8);
        wait_frames(2);
        checks++;
        if (got_q.size() != 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d frames, want 2", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== 11'h400 || got_q[1] !== 11'h5FE) begin
                errors++;
                $display("FAIL b2b_values: got %h %h, want 400 5fe", got_q[0], got_q[1]);
            end
            checks++;
            if (got_tick_q[1] - t1 < LAT_MIN || got_tick_q[1] - t1 > LAT_MAX) begin
                errors++;
                $display("FAIL b2b_latency: got %0d ticks, want %0d..%0d",
                         got_tick_q[1] - t1, LAT_MIN, LAT_MAX);
            end
        end
    endtask

    task automatic test_abort();
        int t0;
        clear_obs();
        send_frame(make_frame(8'($urandom), 1'($urandom), 1'b1), 1'b0, 5, t0);
        idle_ticks(12);
        checks++;
        if (rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy: got %b, want 0", rx_busy);
        end
        rx_enable = 1'b1;
        idle_ticks(20);
        send_frame(make_frame(8'h3C, 1'b0, 1'b1), 1'b0, -1, t0);
        idle_ticks(8);
        wait_frames(1);
        checks++;
        if (got_q.size() != 1) begin
            errors++;
            $display("FAIL abort_count: got %0d frames, want 1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== 11'h478) begin
                errors++;
                $display("FAIL abort_value: got %h, want 478", got_q[0]);
            end
        end
    endtask

    task automatic test_random();
        logic [FB-1:0] exp_q[$];
        int            t0_q[$];
        int            exp_glitch;
        int            g0;
        int            t0;
        logic [FB-1:0] f;
        logic          s;
        int            gap;
        clear_obs();
        g0         = glitch_cnt;
        exp_glitch = 0;
        for (int i = 0; i < 12; i++) begin
            s   = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            f   = make_frame(8'($urandom), 1'($urandom), s);
            // A zero stop bit looks like a new start edge that then fails
            // its centre check, so it needs room to be rejected.
            gap = s ? int'($urandom_range(0, 6)) : int'($urandom_range(8, 12));
            if (!s) exp_glitch++;
            exp_q.push_back(f);
            send_frame(f, 1'b0, -1, t0);
            t0_q.push_back(t0);
            idle_ticks(gap);
        end
        idle_ticks(24);
        wait_frames(12);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_count: got %0d frames, want %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i] ||
                    got_tick_q[i] - t0_q[i] < LAT_MIN || got_tick_q[i] - t0_q[i] > LAT_MAX) begin
                    errors++;
                    $display("FAIL rand_frame[%0d]: got %h after %0d ticks, want %h after %0d..%0d",
                             i, got_q[i], got_tick_q[i] - t0_q[i], exp_q[i], LAT_MIN, LAT_MAX);
                end
            end
        end
        checks++;
        if (glitch_cnt - g0 != exp_glitch) begin
            errors++;
            $display("FAIL rand_glitches: got %0d, want %0d", glitch_cnt - g0, exp_glitch);
        end
    endtask

    task automatic test_spike();
        int         t0;
        logic [7:0] exp_data;
`ifdef RX_MAJORITY_VOTE_EN
        exp_data = 8'h5A;
`else
        exp_data = 8'hA5;
`endif
        fixed_ticks = 1'b1;
        idle_ticks(10);
        clear_obs();
        send_frame(make_frame(8'h5A, 1'b0, 1'b1), 1'b1, -1, t0);
        idle_ticks(8);
        wait_frames(1);
        fixed_ticks = 1'b0;
        checks++;
        if (got_q.size() != 1) begin
            errors++;
            $display("FAIL spike_count: got %0d frames, want 1", got_q.size());
        end else begin
            checks++;
            if (got_q[0][8:1] !== exp_data || got_q[0][0] !== 1'b0 || got_q[0][10:9] !== 2'b10) begin
                errors++;
                $display("FAIL spike_value: got %h, want data %h start 0 parity 0 stop 1",
                         got_q[0], exp_data);
            end
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (frame_parallel !== '0 || rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got fp=%h busy=%b, want 000/0", frame_parallel, rx_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_exclusive();
        checks++;
        if (both_cnt != 0) begin
            errors++;
            $display("FAIL pulse_exclusive: got %0d overlapping cycles, want 0", both_cnt);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        rx_serial = 1'b1;
        rx_enable = 1'b0;
        test_reset();
        test_single_frame();
        test_glitch();
        test_back_to_back();
        test_abort();
        test_random();
        test_spike();
        test_exclusive();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
